// File: rtl/sram22_port_ctrl.sv
// sram22_port_ctrl: valid/ready front end for one sram22 macro with post-reset zero-fill and a credit-checked read FIFO.
module sram22_port_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WMASK_WIDTH = DATA_WIDTH / 8,
    parameter int RSP_DEPTH   = 3,
    parameter bit INIT_ZERO   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   init_done,
    output logic                   sram_rstb,
    output logic                   sram_ce,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);
    localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 2);
    typedef enum logic [1:0] {WAKE, INIT, RUN} state_t;
    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    rd_pending;
    logic [DATA_WIDTH-1:0]   fifo [RSP_DEPTH];
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [CW-1:0]           fifo_cnt;
    logic                    init, fire, push, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(RSP_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // A response popped this cycle does not return its credit until the next one.
    always_comb begin
        init       = state == INIT;
        req_ready  = state == RUN && (req_we || fifo_cnt + CW'(rd_pending) < CW'(RSP_DEPTH));
        fire       = req_valid && req_ready;
        push       = rd_pending;
        rsp_valid  = fifo_cnt != '0;
        pop        = rsp_valid && rsp_ready;
        rsp_rdata  = fifo[rd_ptr];
        sram_ce    = init || fire;
        sram_we    = init || (fire && req_we);
        sram_wmask = init ? '1 : fire ? req_wmask : '0;
        sram_addr  = init ? cnt : fire ? req_addr : '0;
        sram_din   = fire ? req_wdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAKE;
            sram_rstb <= 1'b0;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            sram_rstb <= 1'b1;
            case (state)
                WAKE: if (sram_rstb) begin
                    state     <= INIT_ZERO ? INIT : RUN;
                    init_done <= !INIT_ZERO;
                end
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pending <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_cnt   <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) fifo[i] <= '0;
        end else begin
            rd_pending <= fire && !req_we;
            if (push) begin
                fifo[wr_ptr] <= sram_dout;
                wr_ptr       <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && !pop && fifo_cnt == CW'(RSP_DEPTH)));
endmodule

// File: tb/tb_sram22_port_ctrl.sv
// tb_sram22_port_ctrl: scoreboard bench with a behavioural macro and reference memory.
module tb_sram22_port_ctrl;
    localparam int DW = 32, AW = 9, MW = 4, D = 3, N = 1 << AW;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [MW-1:0] req_wmask = 0;
    logic [AW-1:0] req_addr = 0;
    logic [DW-1:0] req_wdata = 0;
    logic req_ready, rsp_valid, init_done, sram_rstb, sram_ce, sram_we;
    logic [DW-1:0] rsp_rdata, sram_din, sram_dout;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;

    sram22_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(D), .INIT_ZERO(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .init_done(init_done), .sram_rstb(sram_rstb),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout));

    logic req_ready1, rsp_valid1, init_done1, sram_rstb1, sram_ce1, sram_we1;
    logic [DW-1:0] rsp_rdata1, sram_din1;
    logic [MW-1:0] sram_wmask1;
    logic [AW-1:0] sram_addr1;
    sram22_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(D), .INIT_ZERO(0)) u1 (
        .clk(clk), .rst(rst), .req_valid(1'b1), .req_ready(req_ready1), .req_we(1'b0),
        .req_wmask(4'h0), .req_addr(9'h0), .req_wdata(32'h0), .rsp_valid(rsp_valid1),
        .rsp_ready(1'b1), .rsp_rdata(rsp_rdata1), .init_done(init_done1), .sram_rstb(sram_rstb1),
        .sram_ce(sram_ce1), .sram_we(sram_we1), .sram_wmask(sram_wmask1), .sram_addr(sram_addr1),
        .sram_din(sram_din1), .sram_dout(32'h0));

    // Behavioural macro: registered read, byte-masked write, starts full of junk.
    logic [DW-1:0] mac [N];
    always @(posedge clk) if (sram_rstb && sram_ce) begin
        if (sram_we) begin
            for (int b = 0; b < MW; b++) if (sram_wmask[b]) mac[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
        end else sram_dout <= mac[sram_addr];
    end

    logic [DW-1:0] ref_mem [N];
    logic [DW-1:0] q [$];
    int total = 0, bad = 0, waits = 0, rdy_mode = 0;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
        end
    endtask

    task automatic fail(input string n);
        total++;
        bad++;
        $display("FAIL %s got=timeout exp=event t=%0t", n, $time);
    endtask

    task automatic zero_ref();
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
        int n = 0;
        req_valid = 1; req_we = we; req_addr = a; req_wmask = m; req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 300) begin n++; @(negedge clk); end
        waits += n;
        if (!req_ready) fail("req_timeout");
        else if (we) begin
            for (int b = 0; b < MW; b++) if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end else q.push_back(ref_mem[a]);
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    initial forever begin
        @(posedge clk); #2;
        rsp_ready = rdy_mode == 0 ? 1'b0 : rdy_mode == 1 ? 1'b1 : $urandom_range(0, 3) != 0;
    end

    logic stall = 0;
    logic [DW-1:0] last;
    always @(negedge clk) begin
        if (rst) stall = 0;
        else begin
            if (stall && rsp_valid) chk("rdata_hold", rsp_rdata, last);
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
                else chk("rdata", rsp_rdata, q.pop_front());
            end
            stall = rsp_valid && !rsp_ready;
            last  = rsp_rdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 600) begin n++; @(negedge clk); end
        if (!init_done) fail("init_timeout");
    endtask

    initial begin
        for (int i = 0; i < N; i++) mac[i] = $urandom;
        zero_ref();
        req_valid = 1; req_we = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rstb", sram_rstb, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp", {rsp_valid, rsp_rdata}, 0);
        chk("rst_ce", sram_ce, 0);
        req_valid = 0; req_we = 0;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("wake_rstb_before_edge", sram_rstb, 0);
        @(negedge clk);
        chk("wake_rstb", sram_rstb, 1);
        chk("wake_idle", {sram_ce, init_done}, 0);
        chk("u1_wake", {init_done1, req_ready1, sram_ce1}, 0);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (i == 0) chk("u1_run", {init_done1, req_ready1, sram_ce1, sram_we1}, 4'b1110);
            chk("init_cycle", {sram_ce, sram_we, sram_wmask, sram_addr, sram_din, req_ready, init_done},
                {1'b1, 1'b1, 4'hF, AW'(i), 32'h0, 1'b0, 1'b0});
        end
        @(negedge clk);
        chk("init_done_rise", {init_done, sram_ce}, 2'b10);

        rdy_mode = 1;
        @(posedge clk); #1;
        issue(0, 9'h1FF, 4'h0, 0);
        issue(1, 9'h010, 4'hF, 32'hDEADBEEF);
        issue(1, 9'h010, 4'b0100, 32'h00AA0000);
        issue(0, 9'h010, 4'h0, 0);
        @(negedge clk);
        chk("rd_latency_c1", rsp_valid, 0);
        @(negedge clk);
        chk("rd_latency_c2", rsp_valid, 1);
        chk("raw_masked", rsp_rdata, 32'hDEAABEEF);

        for (int i = 0; i < 8; i++) issue(1, AW'(i), 4'hF, $urandom);
        waits = 0;
        for (int i = 0; i < 8; i++) issue(0, AW'(i), 4'h0, 0);
        chk("b2b_no_stall", waits, 0);
        repeat (4) @(negedge clk);
        chk("b2b_drained", q.size(), 0);

        rdy_mode = 0;
        @(posedge clk); #1;
        waits = 0;
        for (int i = 0; i < 3; i++) issue(0, AW'($urandom_range(0, 7)), 4'h0, 0);
        chk("bp_three_accepted", waits, 0);
        req_valid = 1; req_we = 0; req_addr = 5;
        repeat (3) begin
            @(negedge clk);
            chk("bp_read_blocked", {req_ready, rsp_valid}, 2'b01);
        end
        req_we = 1;
        #1 chk("bp_write_ok", req_ready, 1);
        issue(1, 9'h3, 4'hF, 32'h12345678);
        rdy_mode = 1;
        repeat (5) @(negedge clk);
        chk("bp_drained", {q.size() == 0, rsp_valid}, 2'b10);
        @(posedge clk); #1;
        waits = 0;
        issue(0, 9'h3, 4'h0, 0);
        chk("bp_credit_back", waits, 0);
        repeat (3) @(negedge clk);

        rdy_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) issue(0, AW'(i), 4'h0, 0);
        #1 rst = 1;
        #1;
        chk("midrst_rsp", rsp_valid, 0);
        chk("midrst_ce", {sram_ce, sram_rstb}, 0);
        q.delete();
        zero_ref();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk);
        @(negedge clk);
        chk("restart_wake", {sram_rstb, sram_ce}, 2'b10);
        @(negedge clk);
        chk("restart_init0", {sram_ce, sram_we, sram_addr}, {2'b11, 9'h0});
        @(negedge clk);
        chk("restart_init1", sram_addr, 1);
        wait_init();

        rdy_mode = 2;
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++)
            issue($urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), MW'($urandom), $urandom);
        rdy_mode = 1;
        repeat (10) @(negedge clk);
        chk("final_drained", {q.size() == 0, rsp_valid}, 2'b10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
